// File: rtl/cpu_alu_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cpu_alu_seq : opcode sequencer and accumulator that feeds and consumes
//               cpu_alu through a three-state IDLE/EXEC/DONE handshake.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
module cpu_alu_seq #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [3:0]        op_code,
  input  logic [DATA_W-1:0] op_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [4:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_z,
  input  logic              alu_cout,
  output logic [DATA_W-1:0] acc,
  output logic              flag_c,
  output logic              flag_z,
  output logic              res_valid,
  output logic              err
);

  localparam logic [4:0] C_SEL_ZERO = 5'b11111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [3:0]        r_opcode;
  logic [DATA_W-1:0] r_operand;
  logic [4:0]        w_sel_exec;

  // ADC/SBB pick their carry-in form from the flag left by the previous op.
  function automatic logic [4:0] sel_decode(input logic [3:0] code, input logic c);
    logic [4:0] s;
    s = C_SEL_ZERO;
    case (code)
      4'd0:    s = 5'b00000;
      4'd1:    s = 5'b00001;
      4'd2:    s = 5'b00011;
      4'd3:    s = 5'b01100;
      4'd4:    s = 5'b10100;
      4'd5:    s = c ? 5'b00100 : 5'b00000;
      4'd6:    s = c ? 5'b01000 : 5'b01100;
      default: s = C_SEL_ZERO;
    endcase
    return s;
  endfunction

  assign w_sel_exec = sel_decode(r_opcode, flag_c);
  assign alu_sel    = (r_state == S_EXEC) ? w_sel_exec : C_SEL_ZERO;
  assign alu_a      = acc;
  assign alu_b      = r_operand;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_opcode  <= '0;
      r_operand <= '0;
      acc       <= '0;
      flag_c    <= 1'b0;
      flag_z    <= 1'b0;
      op_ready  <= 1'b1;
      res_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (op_valid) begin
            r_opcode  <= op_code;
            r_operand <= op_data;
            op_ready  <= 1'b0;
            r_state   <= S_EXEC;
          end
        end
        S_EXEC: begin
          // Opcodes 8..15 have bit 3 set: no writeback, flag an error instead.
          if (!r_opcode[3]) begin
            acc    <= alu_z;
            flag_c <= alu_cout;
            flag_z <= (alu_z == '0);
          end
          err       <= r_opcode[3];
          res_valid <= 1'b1;
          r_state   <= S_DONE;
        end
        S_DONE: begin
          res_valid <= 1'b0;
          err       <= 1'b0;
          op_ready  <= 1'b1;
          r_state   <= S_IDLE;
        end
        default: begin
          res_valid <= 1'b0;
          err       <= 1'b0;
          op_ready  <= 1'b1;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
